// File: rtl/branch_predictor_if.sv
// Lookup and resolve bundle between fetch/execute and the predictor.
// master drives lookup PC and resolved updates; slave returns predictions.
interface branch_predictor_if #(
   parameter int IDX_W = 4
);
   logic [31:0]      fetch_pc_i;
   logic             pred_hit_o;
   logic             pred_taken_o;
   logic [31:0]      pred_target_o;
   logic [IDX_W-1:0] pred_ghr_o;
   logic             upd_valid_i;
   logic [31:0]      upd_pc_i;
   logic             upd_is_jump_i;
   logic             upd_taken_i;
   logic [31:0]      upd_target_i;
   logic             upd_pred_taken_i;
   logic [31:0]      upd_pred_target_i;
   logic [IDX_W-1:0] upd_ghr_i;
   logic             mispredict_o;

   modport master (
      output fetch_pc_i,
      output upd_valid_i,
      output upd_pc_i,
      output upd_is_jump_i,
      output upd_taken_i,
      output upd_target_i,
      output upd_pred_taken_i,
      output upd_pred_target_i,
      output upd_ghr_i,
      input  pred_hit_o,
      input  pred_taken_o,
      input  pred_target_o,
      input  pred_ghr_o,
      input  mispredict_o
   );

   modport slave (
      input  fetch_pc_i,
      input  upd_valid_i,
      input  upd_pc_i,
      input  upd_is_jump_i,
      input  upd_taken_i,
      input  upd_target_i,
      input  upd_pred_taken_i,
      input  upd_pred_target_i,
      input  upd_ghr_i,
      output pred_hit_o,
      output pred_taken_o,
      output pred_target_o,
      output pred_ghr_o,
      output mispredict_o
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters and registered mispredict flag.
// Define BP_GHR_EN to index the counters by PC index XOR global history.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2
) (
   input logic               clk_i,
   input logic               rst_ni,
   branch_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

   logic             valid_q [ENTRIES];
   logic             jump_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [31:0]      tgt_q   [ENTRIES];
   logic [CNT_W-1:0] cnt_q   [ENTRIES];
   logic             mis_q, mis_d;

   logic [IDX_W-1:0] f_idx, f_cidx;
   logic [IDX_W-1:0] u_idx, u_cidx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             f_hit, f_taken;
   logic             u_hit, wr_en;
   logic [CNT_W-1:0] cnt_cur, cnt_nxt;
   logic             unused_pc;

   assign f_idx = bus.fetch_pc_i[IDX_W+1:2];
   assign f_tag = bus.fetch_pc_i[31:IDX_W+2];
   assign u_idx = bus.upd_pc_i[IDX_W+1:2];
   assign u_tag = bus.upd_pc_i[31:IDX_W+2];
   assign unused_pc = ^{bus.fetch_pc_i[1:0], bus.upd_pc_i[1:0]};

`ifdef BP_GHR_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   assign f_cidx = f_idx ^ ghr_q;
   assign u_cidx = u_idx ^ bus.upd_ghr_i;
   assign bus.pred_ghr_o = ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (bus.upd_valid_i && !bus.upd_is_jump_i)
         ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ghr_q <= '0;
      else         ghr_q <= ghr_d;
   end
`else
   logic unused_ghr;

   assign unused_ghr = ^bus.upd_ghr_i;
   assign f_cidx = f_idx;
   assign u_cidx = u_idx;
   assign bus.pred_ghr_o = '0;
`endif

   assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign f_taken = f_hit && (jump_q[f_idx] || cnt_q[f_cidx][CNT_W-1]);

   assign bus.pred_hit_o    = f_hit;
   assign bus.pred_taken_o  = f_taken;
   assign bus.pred_target_o = f_taken ? tgt_q[f_idx]
                                      : bus.fetch_pc_i + 32'd4;
   assign bus.mispredict_o  = mis_q;

   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign cnt_cur = cnt_q[u_cidx];

   always_comb begin
      wr_en   = 1'b0;
      cnt_nxt = cnt_cur;
      mis_d   = 1'b0;
      if (bus.upd_valid_i) begin
         mis_d = (bus.upd_taken_i != bus.upd_pred_taken_i) ||
                 (bus.upd_taken_i &&
                  (bus.upd_target_i != bus.upd_pred_target_i));
         unique case (1'b1)
            u_hit: begin
               wr_en = 1'b1;
               if (bus.upd_taken_i)
                  cnt_nxt = (cnt_cur == CNT_MAX) ? cnt_cur
                                                 : cnt_cur + CNT_W'(1);
               else
                  cnt_nxt = (cnt_cur == '0) ? cnt_cur
                                            : cnt_cur - CNT_W'(1);
            end
            (!u_hit && bus.upd_taken_i): begin
               wr_en   = 1'b1;
               cnt_nxt = CNT_WT;
            end
            default: ;
         endcase
      end
   end

   // Valid bits and counters carry reset state; payload fields do not.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_WNT;
         end
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
         if (wr_en) begin
            valid_q[u_idx] <= 1'b1;
            cnt_q[u_cidx]  <= cnt_nxt;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_en) begin
         tag_q[u_idx]  <= u_tag;
         tgt_q[u_idx]  <= bus.upd_target_i;
         jump_q[u_idx] <= bus.upd_is_jump_i;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed spec scenarios then random traffic against a table model.
// Model tracks entries and counters as plain integers.
module tb_branch_predictor;
   localparam int ENT  = 16;
   localparam int CW   = 2;
   localparam int IW   = 4;
   localparam int HALF = 1 << (CW - 1);
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_if #(.IDX_W(IW)) bus ();

   branch_predictor #(
      .ENTRIES(ENT),
      .CNT_W  (CW)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   bit          m_v   [ENT];
   bit          m_j   [ENT];
   int unsigned m_tag [ENT];
   logic [31:0] m_tgt [ENT];
   int          m_cnt [ENT];
   int          m_ghr = 0;
   bit          m_mis = 1'b0;

   int total = 0;
   int bad   = 0;

   function automatic int ix(logic [31:0] pc);
      return int'((pc >> 2) % ENT);
   endfunction

   function automatic int unsigned tg(logic [31:0] pc);
      return pc >> (2 + IW);
   endfunction

   function automatic int cix(int i, int g);
`ifdef BP_GHR_EN
      return i ^ g;
`else
      return i + 0 * g;
`endif
   endfunction

   task automatic chk(string t, logic [31:0] o, logic [31:0] e);
      total++;
      assert (o === e)
      else begin
         bad++;
         $error("FAIL %s got=%h want=%h", t, o, e);
      end
   endtask

   task automatic check_lookup();
      logic [31:0] pc;
      int i;
      bit h, t;
      logic [31:0] tgt;
      pc  = bus.fetch_pc_i;
      i   = ix(pc);
      h   = m_v[i] && (m_tag[i] == tg(pc));
      t   = h && (m_j[i] || m_cnt[cix(i, m_ghr)] >= HALF);
      tgt = t ? m_tgt[i] : pc + 32'd4;
      chk("hit", 32'(bus.pred_hit_o), 32'(h));
      chk("taken", 32'(bus.pred_taken_o), 32'(t));
      chk("target", bus.pred_target_o, tgt);
      chk("ghr", 32'(bus.pred_ghr_o), 32'(m_ghr));
   endtask

   task automatic model_edge();
      int i, c;
      bit h, tk;
      if (!rst_n) begin
         for (int k = 0; k < ENT; k++) begin
            m_v[k]   = 1'b0;
            m_cnt[k] = HALF - 1;
         end
         m_ghr = 0;
         m_mis = 1'b0;
      end else if (bus.upd_valid_i) begin
         tk = bus.upd_taken_i;
         i  = ix(bus.upd_pc_i);
         c  = cix(i, int'(bus.upd_ghr_i));
         h  = m_v[i] && (m_tag[i] == tg(bus.upd_pc_i));
         m_mis = (tk != bus.upd_pred_taken_i) ||
                 (tk && bus.upd_target_i != bus.upd_pred_target_i);
         if (h || tk) begin
            m_v[i]   = 1'b1;
            m_tag[i] = tg(bus.upd_pc_i);
            m_tgt[i] = bus.upd_target_i;
            m_j[i]   = bus.upd_is_jump_i;
            if (!h)      m_cnt[c] = HALF;
            else if (tk) m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
            else         m_cnt[c] = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
         end
`ifdef BP_GHR_EN
         if (!bus.upd_is_jump_i) m_ghr = ((m_ghr << 1) | int'(tk)) % ENT;
`endif
      end else begin
         m_mis = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("mispredict", 32'(bus.mispredict_o), 32'(m_mis));
   endtask

   task automatic drive(logic [31:0] f, bit v, logic [31:0] pc, bit j,
                        bit t, logic [31:0] tgt, bit pt,
                        logic [31:0] ptgt);
      bus.fetch_pc_i        = f;
      bus.upd_valid_i       = v;
      bus.upd_pc_i          = pc;
      bus.upd_is_jump_i     = j;
      bus.upd_taken_i       = t;
      bus.upd_target_i      = tgt;
      bus.upd_pred_taken_i  = pt;
      bus.upd_pred_target_i = ptgt;
      bus.upd_ghr_i         = IW'(m_ghr);
   endtask

   task automatic step(logic [31:0] f, bit v, logic [31:0] pc, bit j,
                       bit t, logic [31:0] tgt, bit pt,
                       logic [31:0] ptgt);
      drive(f, v, pc, j, t, tgt, pt, ptgt);
      @(negedge clk);
      check_lookup();
      tick();
   endtask

   task automatic idle(logic [31:0] f);
      step(f, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic upd(logic [31:0] pc, bit j, bit t, logic [31:0] tgt);
      step(pc, 1'b1, pc, j, t, tgt, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] pc, f, tgt, ptgt;
      bit v, j, t, pt;

      // updates presented during reset must be dropped
      rst_n = 1'b0;
      drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      idle(32'h100);
      chk("rst_hit", 32'(bus.pred_hit_o), 32'd0);
      chk("rst_tgt", bus.pred_target_o, 32'h104);
      chk("rst_mis", 32'(bus.mispredict_o), 32'd0);

      step(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      chk("alloc_mis", 32'(bus.mispredict_o), 32'd1);
      idle(32'h100);
      chk("alloc_hit", 32'(bus.pred_hit_o), 32'd1);
`ifndef BP_GHR_EN
      chk("alloc_tgt", bus.pred_target_o, 32'h200);
`endif

      upd(32'h100, 1'b0, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b0, 32'h200);
      idle(32'h100);
`ifndef BP_GHR_EN
      chk("sat_tk", 32'(bus.pred_taken_o), 32'd1);
`endif
      upd(32'h100, 1'b0, 1'b0, 32'h200);
      idle(32'h100);
`ifndef BP_GHR_EN
      chk("sat_nt", 32'(bus.pred_taken_o), 32'd0);
      chk("sat_nt_tgt", bus.pred_target_o, 32'h104);
`endif

      upd(32'h140, 1'b0, 1'b1, 32'h500);
      idle(32'h100);
      chk("alias_old", 32'(bus.pred_hit_o), 32'd0);
      idle(32'h140);
      chk("alias_new", 32'(bus.pred_hit_o), 32'd1);

      upd(32'h80, 1'b0, 1'b1, 32'h40);
      upd(32'h80, 1'b0, 1'b0, 32'h40);
      upd(32'h80, 1'b0, 1'b0, 32'h40);
      upd(32'h80, 1'b1, 1'b1, 32'h10);
      idle(32'h80);
      chk("jump_tk", 32'(bus.pred_taken_o), 32'd1);
      chk("jump_tgt", bus.pred_target_o, 32'h10);

      drive(32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
      @(negedge clk);
      chk("same_old", 32'(bus.pred_hit_o), 32'd0);
      check_lookup();
      tick();
      chk("same_mis", 32'(bus.mispredict_o), 32'd0);
      idle(32'h300);
      chk("same_new", 32'(bus.pred_hit_o), 32'd1);
      upd(32'h300, 1'b0, 1'b0, 32'h600);
      upd(32'h300, 1'b0, 1'b0, 32'h600);
      idle(32'h300);

      for (int n = 0; n < 400; n++) begin
         pc   = 32'h100 + 32'($urandom_range(0, 63)) * 4;
         f    = 32'h100 + 32'($urandom_range(0, 63)) * 4;
         v    = ($urandom_range(0, 3) != 0);
         j    = ($urandom_range(0, 5) == 0);
         t    = j ? 1'b1 : 1'($urandom_range(0, 1));
         tgt  = $urandom & 32'hFFFF_FFFC;
         pt   = 1'($urandom_range(0, 1));
         ptgt = ($urandom_range(0, 1) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
         if ($urandom_range(0, 7) == 0) f = pc;
         step(f, v, pc, j, t, tgt, pt, ptgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning BTB/counter table depth; power of two, 4..256.
REQ-002 SHALL have parameter CNT_W, default 2, meaning saturating-counter width, 1..4.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port fetch_pc_i  input  32  lookup PC.
REQ-006 SHALL have port pred_hit_o  output  1  BTB tag hit for fetch_pc_i.
REQ-007 SHALL have port pred_taken_o  output  1  predicted taken.
REQ-008 SHALL have port pred_target_o  output  32  predicted next PC.
REQ-009 SHALL have port pred_ghr_o  output  IDX_W  current global history, where IDX_W = log2(ENTRIES).
REQ-010 SHALL have port upd_valid_i  input  1  resolved control-flow instruction present.
REQ-011 SHALL have port upd_pc_i  input  32  resolved instruction PC.
REQ-012 SHALL have port upd_is_jump_i  input  1  unconditional jump (JAL/JALR).
REQ-013 SHALL have port upd_taken_i  input  1  actual outcome.
REQ-014 SHALL have port upd_target_i  input  32  actual target.
REQ-015 SHALL have port upd_pred_taken_i  input  1  prediction made at fetch.
REQ-016 SHALL have port upd_pred_target_i  input  32  target predicted at fetch.
REQ-017 SHALL have port upd_ghr_i  input  IDX_W  GHR snapshot captured at fetch.
REQ-018 SHALL have port mispredict_o  output  1  registered mispredict flag.

Function
REQ-019 SHALL form idx = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2].
REQ-020 SHALL make lookup combinational: pred_hit_o = valid[idx] && tag[idx] == tag(fetch_pc_i).
REQ-021 SHALL drive pred_taken_o = pred_hit_o && (jump[idx] || counter MSB set).
REQ-022 SHALL drive pred_target_o = stored target when pred_taken_o, else fetch_pc_i + 4 modulo 2^32.
REQ-023 SHALL perform updates on the rising edge when upd_valid_i; lookup in the same cycle sees pre-update contents.
REQ-024 SHALL, on update hit, write target and jump flag, and saturate the counter: up on taken, down on not-taken, with no wrap past all-ones or zero.
REQ-025 SHALL, on update miss with upd_taken_i=1, allocate the entry (overwriting any victim) with counter weakly-taken (MSB=1, rest 0).
REQ-026 SHALL, on update miss with upd_taken_i=0, leave the table unchanged.
REQ-027 SHALL, on the cycle after an update, assert mispredict_o = (upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i); otherwise deassert it, giving one-cycle latency.
REQ-028 SHALL process back-to-back updates every cycle, and two updates to the same idx in consecutive cycles SHALL apply in order.

Reset
REQ-029 SHALL, while rst_ni=0 at a clock edge, clear all valid bits, set counters to weakly-not-taken (MSB=0, rest 1), clear GHR, and clear mispredict_o.
REQ-030 SHALL ignore any update presented in a reset cycle; outputs after reset SHALL read pred_hit_o=0, pred_taken_o=0, pred_target_o=fetch_pc_i+4.

Configuration
REQ-031 SHALL provide macro BP_GHR_EN: when defined, counter index = idx XOR GHR (lookup uses the live GHR, update uses upd_ghr_i), and the GHR shifts in upd_taken_i on each conditional (non-jump) update.
REQ-032 SHALL, without BP_GHR_EN, index counters by idx only, tie pred_ghr_o to 0, and ignore upd_ghr_i.

Verification
REQ-033 SHALL cover reset then lookup 0x100 -> hit=0, taken=0, target=0x104, mispredict_o=0.
REQ-034 SHALL cover update pc=0x100, taken=1, target=0x200, pred_taken=0 -> next cycle mispredict_o=1; lookup 0x100 -> hit=1, taken=1, target=0x200.
REQ-035 SHALL cover counter saturation: 3 taken updates then 1 not-taken on 0x100 (CNT_W=2) -> still predicts taken; a 2nd not-taken -> predicts not-taken.
REQ-036 SHALL cover aliasing with ENTRIES=16: allocate 0x100, then taken update on 0x140 -> lookup 0x100 hit=0, lookup 0x140 hit=1.
REQ-037 SHALL cover jump update 0x80 -> 0x10 with counter forced to 0 -> pred_taken_o=1, target=0x10.
REQ-038 SHALL cover same-cycle lookup and update of 0x300 -> old result that cycle, new result next cycle; with BP_GHR_EN, pred_ghr_o shifts on conditional updates only.
